saturn_bus_responder: RTL and testbench

//  Target end of the Saturn nibble bus; the core is the initiator. Keeps its own PC and DP

---
 rtl/saturn_bus_pkg.sv | 20 ++
 rtl/saturn_addr_loader.sv | 47 ++++
 rtl/saturn_bus_responder.sv | 167 ++++++++++++++++
 tb/tb_saturn_bus_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_bus_pkg.sv
// rtl/saturn_bus_pkg.sv - Saturn nibble bus command encodings, FSM states and defaults
package saturn_bus_pkg;

    localparam int SATURN_ADDR_W = 20;

    localparam logic [3:0] BUS_NOP      = 4'd0;
    localparam logic [3:0] BUS_PC_READ  = 4'd1;
    localparam logic [3:0] BUS_DP_READ  = 4'd2;
    localparam logic [3:0] BUS_DP_WRITE = 4'd3;
    localparam logic [3:0] BUS_LOAD_PC  = 4'd4;
    localparam logic [3:0] BUS_LOAD_DP  = 4'd5;
    localparam logic [3:0] BUS_RESET    = 4'd7;

    // Two bits so that corrupted encodings exist and can be steered back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1
    } bus_state_t;

endpackage

// File: rtl/saturn_addr_loader.sv
// rtl/saturn_addr_loader.sv - LSN-first nibble collector for PC/DP address loads
module saturn_addr_loader #(
    parameter int ADDR_W    = 20,
    parameter int ADDR_NIBS = ADDR_W / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift,
    input  logic [3:0]        nibble,
    output logic [ADDR_W-1:0] value,
    output logic              last,
    output logic              commit
);

    localparam int CNT_W = (ADDR_NIBS > 1) ? $clog2(ADDR_NIBS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ADDR_NIBS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] shadow;

    // value merges the incoming nibble so the final nibble lands in the same edge as the commit.
    always_comb begin
        value = shadow;
        for (int i = 0; i < ADDR_NIBS; i++) begin
            if (cnt == CNT_W'(i)) begin
                value[4*i +: 4] = nibble;
            end
        end
    end

    assign last   = (cnt == LAST_IDX);
    assign commit = shift && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (shift) begin
            shadow <= value;
            cnt    <= commit ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/saturn_bus_responder.sv
// rtl/saturn_bus_responder.sv - Saturn nibble bus target with PC/DP pointers fronting nibble memory
module saturn_bus_responder
    import saturn_bus_pkg::*;
#(
    parameter int                ADDR_W    = SATURN_ADDR_W,
    parameter int                ADDR_NIBS = ADDR_W / 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en_bus_send,
    input  logic              i_en_bus_recv,
    input  logic [3:0]        i_cmd,
    input  logic [3:0]        i_nibble,
    output logic [3:0]        o_nibble,
    output logic              o_nibble_valid,
    output logic              o_bus_error,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_wdata,
    input  logic [3:0]        i_mem_rdata
);

    bus_state_t        state;
    bus_state_t        state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] dp;
    logic              read_pending;
    logic              load_is_dp;

    logic              rd_pc;
    logic              rd_dp;
    logic              wr_dp;
    logic              load_start;
    logic              bus_reset;
    logic              illegal;
    logic              shift;
    logic              load_last;
    logic              load_commit;
    logic [ADDR_W-1:0] load_value;

    saturn_addr_loader #(
        .ADDR_W    (ADDR_W),
        .ADDR_NIBS (ADDR_NIBS)
    ) u_loader (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .clear  (load_start | bus_reset),
        .shift  (shift),
        .nibble (i_nibble),
        .value  (load_value),
        .last   (load_last),
        .commit (load_commit)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_pc      = 1'b0;
        rd_dp      = 1'b0;
        wr_dp      = 1'b0;
        load_start = 1'b0;
        bus_reset  = 1'b0;
        illegal    = 1'b0;
        shift      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_en_bus_send && i_cmd != BUS_RESET) begin
                    case (i_cmd)
                        BUS_NOP:      ;
                        BUS_PC_READ:  rd_pc = 1'b1;
                        BUS_DP_READ:  rd_dp = 1'b1;
                        BUS_DP_WRITE: wr_dp = 1'b1;
                        BUS_LOAD_PC, BUS_LOAD_DP: begin
                            load_start = 1'b1;
                            state_next = ST_LOAD;
                        end
                        default:      illegal = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                // Every non-reset send strobe carries an address nibble; the command is don't-care.
                if (i_en_bus_send && i_cmd != BUS_RESET) begin
                    shift = 1'b1;
                    if (load_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (i_en_bus_send && i_cmd == BUS_RESET) begin
            bus_reset  = 1'b1;
            state_next = ST_IDLE;
        end
    end

    assign o_mem_en    = i_reset_n & (rd_pc | rd_dp | wr_dp);
    assign o_mem_we    = i_reset_n & wr_dp;
    assign o_mem_addr  = (rd_dp || wr_dp) ? dp : pc;
    assign o_mem_wdata = i_nibble;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc             <= RESET_PC;
            dp             <= '0;
            read_pending   <= 1'b0;
            load_is_dp     <= 1'b0;
            o_nibble       <= 4'h0;
            o_nibble_valid <= 1'b0;
            o_bus_error    <= 1'b0;
        end else begin
            o_nibble_valid <= 1'b0;
            // Recv is served from the read issued earlier, even when a new send arrives this clock.
            if (i_en_bus_recv && read_pending) begin
                o_nibble       <= i_mem_rdata;
                o_nibble_valid <= 1'b1;
            end

            if (bus_reset) begin
                read_pending <= 1'b0;
            end else if (rd_pc || rd_dp) begin
                read_pending <= 1'b1;
            end else if (i_en_bus_recv) begin
                read_pending <= 1'b0;
            end

            if (load_start) begin
                load_is_dp <= (i_cmd == BUS_LOAD_DP);
            end

            if (bus_reset) begin
                pc <= RESET_PC;
                dp <= '0;
            end else begin
                if (load_commit && !load_is_dp) begin
                    pc <= load_value;
                end else if (rd_pc) begin
                    pc <= pc + ADDR_W'(1);
                end
                if (load_commit && load_is_dp) begin
                    dp <= load_value;
                end else if (rd_dp || wr_dp) begin
                    dp <= dp + ADDR_W'(1);
                end
            end

            if (bus_reset) begin
                o_bus_error <= 1'b0;
            end else if (illegal) begin
                o_bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_saturn_bus_responder.sv
// tb/tb_saturn_bus_responder.sv - scoreboard bench for saturn_bus_responder with nibble RAM model
module tb_saturn_bus_responder;

    localparam int unsigned ADDR_SPACE = 32'h0010_0000;

    logic        clk;
    logic        i_reset_n;
    logic        i_en_bus_send;
    logic        i_en_bus_recv;
    logic [3:0]  i_cmd;
    logic [3:0]  i_nibble;
    logic [3:0]  o_nibble;
    logic        o_nibble_valid;
    logic        o_bus_error;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [19:0] o_mem_addr;
    logic [3:0]  o_mem_wdata;
    logic [3:0]  mem_rdata;

    int checks = 0;
    int fails  = 0;

    saturn_bus_responder dut (
        .i_clk          (clk),
        .i_reset_n      (i_reset_n),
        .i_en_bus_send  (i_en_bus_send),
        .i_en_bus_recv  (i_en_bus_recv),
        .i_cmd          (i_cmd),
        .i_nibble       (i_nibble),
        .o_nibble       (o_nibble),
        .o_nibble_valid (o_nibble_valid),
        .o_bus_error    (o_bus_error),
        .o_mem_en       (o_mem_en),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations hold a fixed address-derived pattern.
    function automatic logic [3:0] init_nib(input int unsigned a);
        return 4'(a ^ (a >> 5) ^ (a >> 11) ^ 32'd3);
    endfunction

    logic [3:0] ram     [int unsigned];
    logic [3:0] mdl_mem [int unsigned];

    function automatic logic [3:0] ram_read(input int unsigned a);
        return ram.exists(a) ? ram[a] : init_nib(a);
    endfunction

    function automatic logic [3:0] mdl_read(input int unsigned a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_nib(a);
    endfunction

    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) ram[{12'b0, o_mem_addr}] = o_mem_wdata;
            else          mem_rdata <= ram_read({12'b0, o_mem_addr});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    int unsigned m_pc, m_dp;
    bit          m_loading, m_load_dp, m_err, m_pending;
    int unsigned m_nibs[$];
    logic [3:0]  m_pend_data, m_last;
    logic [3:0]  exp_q[$];

    task automatic model_reset(input bit full);
        m_pc = 0; m_dp = 0; m_loading = 0; m_nibs.delete();
        m_pending = 0; m_err = 0;
        if (full) m_last = 4'h0;
    endtask

    always @(negedge clk) begin
        if (i_reset_n && o_nibble_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: got o_nibble=%0h, expected no valid pulse", o_nibble);
            end else begin
                check("read_data", {28'b0, o_nibble}, {28'b0, exp_q.pop_front()});
            end
        end
    end

    // One bus clock: model first (recv before send), then drive, check memory port, clock.
    task automatic step(input bit send, input logic [3:0] cmd, input logic [3:0] nib, input bit recv);
        bit          exp_en, exp_we;
        int unsigned exp_addr, val;
        exp_en = 0; exp_we = 0; exp_addr = 0;
        if (recv && m_pending) begin
            exp_q.push_back(m_pend_data);
            m_last    = m_pend_data;
            m_pending = 0;
        end
        if (send) begin
            if (cmd == 4'd7) begin
                model_reset(0);
            end else if (m_loading) begin
                m_nibs.push_back(int'(nib));
                if (m_nibs.size() == 5) begin
                    val = 0;
                    foreach (m_nibs[i]) val += m_nibs[i] << (4 * i);
                    if (m_load_dp) m_dp = val;
                    else           m_pc = val;
                    m_loading = 0;
                    m_nibs.delete();
                end
            end else begin
                case (cmd)
                    4'd0: ;
                    4'd1: begin
                        exp_en = 1; exp_addr = m_pc;
                        m_pend_data = mdl_read(m_pc); m_pending = 1;
                        m_pc = (m_pc + 1) % ADDR_SPACE;
                    end
                    4'd2: begin
                        exp_en = 1; exp_addr = m_dp;
                        m_pend_data = mdl_read(m_dp); m_pending = 1;
                        m_dp = (m_dp + 1) % ADDR_SPACE;
                    end
                    4'd3: begin
                        exp_en = 1; exp_we = 1; exp_addr = m_dp;
                        mdl_mem[m_dp] = nib;
                        m_dp = (m_dp + 1) % ADDR_SPACE;
                    end
                    4'd4, 4'd5: begin
                        m_loading = 1; m_load_dp = (cmd == 4'd5);
                    end
                    default: m_err = 1;
                endcase
            end
        end
        i_en_bus_send = send; i_cmd = cmd; i_nibble = nib; i_en_bus_recv = recv;
        #1;
        check("mem_en", {31'b0, o_mem_en}, {31'b0, exp_en});
        check("mem_we", {31'b0, o_mem_we}, {31'b0, exp_we});
        if (exp_en) check("mem_addr", {12'b0, o_mem_addr}, exp_addr);
        if (exp_we) check("mem_wdata", {28'b0, o_mem_wdata}, {28'b0, nib});
        @(posedge clk);
        #1;
        i_en_bus_send = 0; i_en_bus_recv = 0; i_cmd = 4'd0; i_nibble = 4'd0;
        check("bus_error", {31'b0, o_bus_error}, {31'b0, m_err});
        if (recv) check("nibble_hold", {28'b0, o_nibble}, {28'b0, m_last});
    endtask

    task automatic rd(input logic [3:0] cmd);
        step(1, cmd, 4'd0, 0);
        step(0, 4'd0, 4'd0, 1);
    endtask

    logic [3:0] cmd_tab [13] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
                                 4'd4, 4'd5, 4'd7, 4'd14, 4'd6, 4'd0};

    initial begin
        i_reset_n = 0; i_en_bus_send = 0; i_en_bus_recv = 0; i_cmd = 0; i_nibble = 0;
        ram[0] = 4'hA; ram[1] = 4'hB; ram[2] = 4'hC;
        mdl_mem[0] = 4'hA; mdl_mem[1] = 4'hB; mdl_mem[2] = 4'hC;
        model_reset(1);
        repeat (3) @(posedge clk);
        @(negedge clk) i_reset_n = 1;
        @(posedge clk); #1;
        check("reset_nibble", {28'b0, o_nibble}, 32'h0);
        check("reset_valid", {31'b0, o_nibble_valid}, 32'h0);
        check("reset_error", {31'b0, o_bus_error}, 32'h0);

        // 1: sequential PC reads
        repeat (3) rd(4'd1);
        // 2: LOAD_PC 0x12345 LSN first, then read from it
        step(1, 4'd4, 4'd0, 0);
        for (int i = 5; i >= 1; i--) step(1, 4'd0, 4'(i), 0);
        rd(4'd1);
        // 3: DP wrap through writes
        step(1, 4'd5, 4'd0, 0);
        repeat (5) step(1, 4'd0, 4'hF, 0);
        step(1, 4'd3, 4'h9, 0);
        step(1, 4'd3, 4'h6, 0);
        rd(4'd2);
        check("mem_fffff", {28'b0, ram_read(32'hFFFFF)}, 32'h9);
        check("mem_00000", {28'b0, ram_read(32'h0)}, 32'h6);
        // 4: BUS_RESET aborts a partial load
        step(1, 4'd4, 4'd0, 0);
        step(1, 4'd0, 4'h8, 0);
        step(1, 4'd0, 4'h8, 0);
        step(1, 4'd7, 4'd0, 0);
        rd(4'd1);
        // 5: illegal command is sticky until BUS_RESET
        step(1, 4'hE, 4'd0, 0);
        repeat (3) step(1, 4'd0, 4'd0, 1);
        step(1, 4'd7, 4'd0, 0);
        // 6: async reset mid-load with a read pending and error set
        step(1, 4'hE, 4'd0, 0);
        rd(4'd1);
        step(1, 4'd1, 4'd0, 0);
        step(1, 4'd5, 4'd0, 0);
        step(1, 4'd0, 4'h3, 0);
        #2;
        i_reset_n = 0;
        #1;
        check("async_nibble", {28'b0, o_nibble}, 32'h0);
        check("async_valid", {31'b0, o_nibble_valid}, 32'h0);
        check("async_error", {31'b0, o_bus_error}, 32'h0);
        i_en_bus_send = 1; i_cmd = 4'd3;
        #1;
        check("reset_mem_en", {31'b0, o_mem_en}, 32'h0);
        check("reset_mem_we", {31'b0, o_mem_we}, 32'h0);
        i_en_bus_send = 0; i_cmd = 4'd0;
        model_reset(1);
        @(negedge clk) i_reset_n = 1;
        @(posedge clk); #1;
        step(0, 4'd0, 4'd0, 1);
        rd(4'd2);

        // Randomized traffic, including same-clock send+recv
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) != 0, cmd_tab[$urandom_range(0, 12)],
                 4'($urandom), $urandom_range(0, 1) == 1);
        end
        step(1, 4'd7, 4'd0, 0);
        rd(4'd1);
        step(0, 4'd0, 4'd0, 1);
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);
        foreach (mdl_mem[k]) check("mem_content", {28'b0, ram_read(k)}, {28'b0, mdl_mem[k]});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
